// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer for an external bit-serial CRC-8 engine. Clears the engine at
// frame start, feeds each byte with a one-cycle enable, forwards bytes
// downstream once the engine completes, then appends the CRC (generate mode)
// or compares the final byte against it (check mode).
module crc8_frame_ctrl #(
  // Engine completion timeout in cycles; legal range 10..15 (4-bit counter).
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_gen,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [7:0] crc_byte,
  output logic       crc_enable,
  output logic       crc_clr,
  input  logic       crc_complete,
  input  logic [7:0] crc_value,
  output logic       frame_done,
  output logic       crc_err,
  output logic       eng_fault
);

  typedef enum logic [3:0] {
    StIdle,
    StClr,
    StFeed,
    StWait,
    StEmit,
    StNext,
    StAppend,
    StDone,
    StFault
  } state_e;

  localparam logic [3:0] TmoLast = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       mode_q, mode_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       fault_q, fault_d;
  logic       take_mid;

  // A mid-frame byte is taken either in the emit handshake cycle or from the
  // wait-for-input state.
  assign take_mid = in_valid &&
                    ((state_q == StNext) || (state_q == StEmit && out_ready && !last_q));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= 4'h0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and latch logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          mode_d  = mode_gen;
          err_d   = 1'b0;
          // A single-byte check frame has nothing to feed: compare directly.
          state_d = (!mode_gen && in_last) ? StEmit : StClr;
        end
      end
      StClr:  state_d = StFeed;
      StFeed: begin
        cnt_d   = 4'h0;
        state_d = StWait;
      end
      StWait: begin
        if (crc_complete) begin
          state_d = StEmit;
        end else if (cnt_q == TmoLast) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (!last_q) begin
            state_d = StNext;
          end else if (mode_q) begin
            state_d = StAppend;
          end else begin
            err_d   = (data_q != crc_value);
            state_d = StDone;
          end
        end
      end
      StNext: begin
      end
      StAppend: begin
        if (out_ready) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      StFault: begin
      end
      default: state_d = StIdle;
    endcase
    // In check mode the final byte bypasses the engine and goes straight to compare.
    if (take_mid) begin
      data_d  = in_data;
      last_d  = in_last;
      state_d = (!mode_q && in_last) ? StEmit : StFeed;
    end
  end

  // Output decode from state.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    crc_enable = 1'b0;
    crc_clr    = 1'b0;
    frame_done = 1'b0;
    crc_err    = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StClr:   crc_clr = 1'b1;
      StFeed:  crc_enable = 1'b1;
      StEmit: begin
        out_valid = 1'b1;
        out_data  = data_q;
        out_last  = !mode_q && last_q;
        in_ready  = out_ready && !last_q;
      end
      StNext:  in_ready = 1'b1;
      StAppend: begin
        out_valid = 1'b1;
        out_data  = crc_value;
        out_last  = 1'b1;
      end
      StDone: begin
        frame_done = 1'b1;
        crc_err    = err_q;
      end
      default: begin
      end
    endcase
  end

  // Byte stays on the engine input from the enable pulse until the next byte is latched.
  assign crc_byte  = data_q;
  assign eng_fault = fault_q;

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
module tb_crc8_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_gen, in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic [7:0] crc_byte, crc_value;
  logic       crc_enable, crc_clr, crc_complete;
  logic       frame_done, crc_err, eng_fault;

  crc8_frame_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .mode_gen(mode_gen), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .crc_byte(crc_byte),
    .crc_enable(crc_enable), .crc_clr(crc_clr), .crc_complete(crc_complete),
    .crc_value(crc_value), .frame_done(frame_done), .crc_err(crc_err),
    .eng_fault(eng_fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_step(logic [7:0] c, logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // Engine stub: completes 9 cycles after the enable pulse.
  bit         stub_dead, stub_fixed;
  logic [7:0] stub_fix_val, stub_crc, stub_cap;
  int         stub_cd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_crc <= 8'h00;
      stub_cap <= 8'h00;
      stub_cd  <= 0;
    end else begin
      if (crc_clr) stub_crc <= 8'h00;
      if (crc_enable && !stub_dead) begin
        stub_cd  <= 1;
        stub_cap <= crc_byte;
      end else if (stub_cd == 9) begin
        stub_cd  <= 0;
        stub_crc <= crc8_step(stub_crc, stub_cap);
      end else if (stub_cd != 0) begin
        stub_cd <= stub_cd + 1;
      end
    end
  end
  assign crc_complete = (stub_cd == 9);
  assign crc_value    = stub_fixed ? stub_fix_val : stub_crc;

  // Scoreboard
  typedef struct {logic [7:0] d; logic l;} beat_t;
  typedef struct {logic err; int n_en; int n_clr;} frame_t;
  beat_t      exp_q[$];
  frame_t     frm_q[$];
  logic [7:0] model_eng;  // what the engine holds after the last fed byte
  bit         rand_bp;
  int         gap_max;

  // Expected CRC the frame's end sees (real engine content, before fixed override).
  function automatic logic [7:0] frame_crc(bit gen, logic [7:0] b[$]);
    logic [7:0] c;
    int nf;
    nf = gen ? b.size() : b.size() - 1;
    if (nf == 0) return model_eng;
    c = 8'h00;
    for (int i = 0; i < nf; i++) c = crc8_step(c, b[i]);
    return c;
  endfunction

  task automatic push_byte(logic [7:0] d, logic l, logic m);
    int w;
    w = 0;
    repeat ($urandom_range(0, gap_max)) @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode_gen = m;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 400);
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(bit gen, logic [7:0] b[$]);
    int         n;
    logic [7:0] c;
    frame_t     f;
    n = b.size();
    c = frame_crc(gen, b);
    if (gen || n > 1) model_eng = c;
    if (stub_fixed) c = stub_fix_val;
    for (int i = 0; i < n; i++) exp_q.push_back('{d: b[i], l: !gen && (i == n - 1)});
    if (gen) exp_q.push_back('{d: c, l: 1'b1});
    f.err   = !gen && (b[n-1] != c);
    f.n_en  = gen ? n : n - 1;
    f.n_clr = (!gen && n == 1) ? 0 : 1;
    frm_q.push_back(f);
    for (int i = 0; i < n; i++)
      push_byte(b[i], i == n - 1, (i == 0) ? gen : 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || frm_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", exp_q.size() + frm_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_ctl"}, {out_valid, out_last, crc_enable, crc_clr, frame_done, crc_err,
                           eng_fault}, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_crc_byte"}, crc_byte, 0);
  endtask

  // Random downstream backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    int en_cnt, clr_cnt, pend_t;
    beat_t e;
    frame_t f;
    en_cnt = 0;
    clr_cnt = 0;
    pend_t = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cnt = 0;
        clr_cnt = 0;
        pend_t = -1;
      end else begin
        if (crc_enable) begin
          en_cnt++;
          if (!stub_dead) pend_t = cyc + 10;
        end
        if (crc_clr) clr_cnt++;
        if (stub_cd != 0) check("crc_byte_hold", crc_byte, stub_cap);
        if (pend_t >= 0 && cyc == pend_t - 1) check("out_valid_early", out_valid, 0);
        if (pend_t >= 0 && cyc == pend_t) begin
          check("out_valid_at_t10", out_valid, 1);
          pend_t = -1;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_out_beat");
          else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.d);
            check("out_last", out_last, e.l);
          end
        end
        if (frame_done) begin
          if (frm_q.size() == 0) fail_now("unexpected_frame_done");
          else begin
            f = frm_q.pop_front();
            check("crc_err", crc_err, f.err);
            check("enable_pulses", en_cnt, f.n_en);
            check("clr_pulses", clr_cnt, f.n_clr);
          end
          en_cnt = 0;
          clr_cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [7:0] bq[$];
    int w, t;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    mode_gen = 1'b0;
    out_ready = 1'b1;
    stub_dead = 1'b0;
    stub_fixed = 1'b1;
    stub_fix_val = 8'hA7;
    rand_bp = 1'b0;
    gap_max = 0;
    model_eng = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed frames against a fixed-value engine
    bq = {8'h12, 8'h34, 8'h56};
    send_frame(1'b1, bq);
    wait_drain();
    bq = {8'h12, 8'h34, 8'hA7};
    send_frame(1'b0, bq);
    wait_drain();
    bq = {8'h12, 8'h34, 8'hA6};
    send_frame(1'b0, bq);
    wait_drain();
    bq = {8'hA7};
    send_frame(1'b0, bq);
    wait_drain();

    // Backpressure hold for 5 cycles on the first emitted byte
    out_ready = 1'b0;
    bq = {8'h5A, 8'h3C};
    fork
      send_frame(1'b1, bq);
      begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 100);
        if (!out_valid) fail_now("bp_out_valid_timeout");
        repeat (5) begin
          check("bp_data_stable", out_data, 8'h5A);
          check("bp_no_enable", crc_enable, 0);
          check("bp_in_ready", in_ready, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Dead engine: timeout after 15 wait cycles, sticky until reset
    stub_dead = 1'b1;
    push_byte(8'h99, 1'b1, 1'b1);
    w = 0;
    while (!crc_enable && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!crc_enable) fail_now("fault_enable_timeout");
    t = cyc;
    while (cyc < t + 15) @(negedge clk);
    check("fault_not_early", eng_fault, 0);
    @(negedge clk);
    check("fault_set", eng_fault, 1);
    @(posedge clk);
    #1 in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("fault_in_ready", in_ready, 0);
      check("fault_out_valid", out_valid, 0);
      check("fault_sticky", eng_fault, 1);
    end
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("fault_cleared", eng_fault, 0);
    stub_dead = 1'b0;
    model_eng = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset during the wait for byte 2
    exp_q.push_back('{d: 8'h11, l: 1'b0});
    push_byte(8'h11, 1'b0, 1'b1);
    push_byte(8'h22, 1'b1, 1'b1);
    w = 0;
    while (!crc_enable && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!crc_enable) fail_now("abort_enable_timeout");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    check("abort_queue", exp_q.size() + frm_q.size(), 0);
    exp_q.delete();
    frm_q.delete();
    model_eng = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bq = {8'hAB};
    send_frame(1'b1, bq);
    wait_drain();

    // Randomized frames against a real CRC engine stub
    stub_fixed = 1'b0;
    rand_bp = 1'b1;
    gap_max = 3;
    for (int k = 0; k < 40; k++) begin
      bit gen;
      int n;
      gen = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 5);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
      if (!gen && $urandom_range(0, 1) == 1) bq[n-1] = frame_crc(1'b0, bq);
      send_frame(gen, bq);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
